instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Instruction-memory responder for the single-cycle RISC-V core: serves the core's fetch port (`pc` in, `instr` out) from an internal word-addressed RAM. After reset it receives a program image over a byte stream, fills the RAM, and only then releases the core from reset. It sits between the host-link receiver (UART byte stream) and the core's instruction port in the top-level.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- `ADDR_W`, $clog2(DEPTH_WORDS): word-index width; derived, not overridden.

Ports:
- `clk1`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  incoming image byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte; a transfer happens on a rising edge with `rx_valid & rx_ready`.
- `pc`  in  32  core fetch address (byte address).
- `instr`  out  32  instruction word at `pc`.
- `core_reset`  out  1  active-high reset to the core; high until load completes.
- `load_done`  out  1  image loaded; core running.
- `load_error`  out  1  image rejected; sticky until `reset`.

## Operation
- Image format, all little-endian: 4-byte word count N, then N words of 4 bytes each (plus a trailer, see Configuration).
- States: HDR (collect 4 count bytes), DATA (collect words), CHK (only with the macro), RUN, ERR.
- Reset state is HDR. Byte counter (2 bits), word counter (`ADDR_W+1` bits) and count register all clear.
- HDR → DATA after the 4th count byte when 0 < N ≤ DEPTH_WORDS.
- HDR → RUN when N = 0.
- HDR → ERR when N > DEPTH_WORDS. All 32 bits of N are compared; no truncation.
- DATA: the 4th byte of each word writes RAM[word counter] and increments the counter.
  - After word N−1 is written: → RUN, or → CHK when the macro is defined.
- RUN and ERR are terminal until `reset`. Further stream bytes are not accepted.
- Fetch: `instr` = RAM[`pc[ADDR_W+1:2]`], combinational asynchronous read.
  - `pc[1:0]` is ignored.
  - Upper `pc` bits are ignored, so addresses wrap modulo DEPTH_WORDS×4.
- In any state other than RUN, `instr` = 32'h0000_0013 (NOP).
- Words past N keep stale contents.
- `reset` asserted mid-load: all control state returns to HDR and `core_reset` reasserts. RAM contents are not cleared.

## Timing
- Reset values: `rx_ready`=0, `core_reset`=1, `load_done`=0, `load_error`=0, `instr`=NOP.
- `rx_ready` is registered. It rises on the first `clk1` edge after `reset` deasserts.
  - It is 1 throughout HDR, DATA and CHK, with no back-pressure gaps.
  - It falls on the same edge that enters RUN or ERR, so no byte beyond the final one is accepted.
- RAM write lands on the edge accepting the word's 4th byte. A fetch of that word sees it from the next cycle.
- `load_done` rises and `core_reset` falls on the edge entering RUN. That is the edge accepting the last byte, or the 4th header byte when N=0.
- `load_error` rises on the edge entering ERR. `core_reset` stays 1 in ERR.
- `rx_valid` low stalls all counters. Byte gaps of any length are legal.

## Configuration
- `IMEM_CHECKSUM_EN` defined:
  - After the N data words, a 4-byte trailer holds the mod-2^32 sum of the N words.
  - CHK collects the trailer. On match → RUN; on mismatch → ERR.
  - With N=0, the trailer (expected 0) is still required, and HDR → CHK.
- Not defined: no trailer and no CHK state; the last data byte goes directly to RUN.

## Test plan
- Reset release, then stream N=3 and words 0x00500093, 0x00A00113, 0x002081B3. Required:
  - `load_done`=1 and `core_reset`=0 on the edge accepting byte 16.
  - `pc`=0x8 → `instr`=0x002081B3.
  - `rx_ready`=0 afterwards.
- N=0 header. Required: RUN immediately after the 4 header bytes (no macro), and `instr`=NOP never returned afterward except from stale RAM.
- N=DEPTH_WORDS+1 (e.g. 0x00000401 at default depth). Required:
  - `load_error`=1 and `core_reset` held at 1.
  - `rx_ready`=0, and `instr`=0x00000013 for any `pc`.
- `rx_valid` toggled randomly with gaps of up to 20 cycles during a 2-word load. Required: identical RAM contents and `load_done` on the last accepted byte.
- Reset asserted after 6 bytes of a load, then a full reload. Required:
  - `core_reset`=1 immediately on assertion.
  - After reload, the second image's words are fetched correctly.
  - `pc`=0x1000 aliases `pc`=0x0 at DEPTH_WORDS=1024.
- With `IMEM_CHECKSUM_EN`: N=2, words 0x1, 0x2. Required: trailer 0x00000003 → `load_done`=1; trailer 0x00000004 → `load_error`=1.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader/responder: fills a word RAM from a byte stream, then serves core fetches.
// Optional trailer checksum state enabled by defining IMEM_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [2:0] {
        StHdr,
        StData,
`ifdef IMEM_CHECKSUM_EN
        StChk,
`endif
        StRun,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [23:0]       byte_buf_q, byte_buf_d;
    logic              rx_ready_q, rx_ready_d;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif

    logic [31:0]       mem [DEPTH_WORDS];
    logic              accept;
    logic              last_byte;
    logic              mem_we;
    logic [31:0]       full_word;
    logic              unused_pc;

    assign accept    = rx_valid & rx_ready_q;
    assign last_byte = accept && (byte_cnt_q == 2'd3);
    // Little-endian: earlier bytes sit in the low lanes of the buffer.
    assign full_word = {rx_data, byte_buf_q};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        count_d    = count_q;
        byte_buf_d = byte_buf_q;
        mem_we     = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            byte_buf_d = {rx_data, byte_buf_q[23:8]};
        end
        case (state_q)
            StHdr: begin
                if (last_byte) begin
                    if (full_word == 32'd0) begin
`ifdef IMEM_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StRun;
`endif
                    end else if (full_word > 32'(DEPTH_WORDS)) begin
                        state_d = StErr;
                    end else begin
                        count_d = full_word[ADDR_W:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (last_byte) begin
                    mem_we     = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
`ifdef IMEM_CHECKSUM_EN
                    sum_d      = sum_q + full_word;
                    if (word_cnt_d == count_q) state_d = StChk;
`else
                    if (word_cnt_d == count_q) state_d = StRun;
`endif
                end
            end
`ifdef IMEM_CHECKSUM_EN
            StChk: begin
                if (last_byte) state_d = (full_word == sum_q) ? StRun : StErr;
            end
`endif
            default: ;
        endcase
        // Registered ready follows the next state so it drops on the terminal edge.
        rx_ready_d = (state_d != StRun) && (state_d != StErr);
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state_q    <= StHdr;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            count_q    <= '0;
            byte_buf_q <= '0;
            rx_ready_q <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            count_q    <= count_d;
            byte_buf_q <= byte_buf_d;
            rx_ready_q <= rx_ready_d;
`ifdef IMEM_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // RAM is deliberately not reset so a reload can leave stale words beyond N.
    always_ff @(posedge clk1) begin
        if (mem_we) mem[word_cnt_q[ADDR_W-1:0]] <= full_word;
    end

    assign unused_pc  = ^{pc[31:ADDR_W+2], pc[1:0]};
    assign rx_ready   = rx_ready_q;
    assign load_done  = (state_q == StRun);
    assign load_error = (state_q == StErr);
    assign core_reset = ~load_done;
    assign instr      = load_done ? mem[pc[ADDR_W+1:2]] : NOP;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against an image-level RAM/outcome model.
module tb_instr_mem_loader;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk1 = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] pc = 32'h0;
    logic [31:0] instr;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] img [$];
    int          chk_delta = 0;

    instr_mem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk1       (clk1),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .pc         (pc),
        .instr      (instr),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok,
                             output logic done_before);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk1);
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (rx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk1);
        end
        done_before = load_done;
        if (ok) @(negedge clk1);
        rx_valid = 1'b0;
    endtask

    task automatic load_image(input logic [31:0] n, input int max_gap, output bit ok,
                              output logic done_before);
        logic [7:0]  bq [$];
        logic [31:0] sum;
        bit          ok_b;
        sum = 32'h0;
        for (int k = 0; k < 4; k++) bq.push_back(n[8*k +: 8]);
        if (n <= DEPTH) begin
            for (int i = 0; i < int'(n); i++) begin
                for (int k = 0; k < 4; k++) bq.push_back(img[i][8*k +: 8]);
                sum = sum + img[i];
            end
`ifdef IMEM_CHECKSUM_EN
            sum = sum + 32'(chk_delta);
            for (int k = 0; k < 4; k++) bq.push_back(sum[8*k +: 8]);
`endif
        end
        ok = 1'b1;
        done_before = 1'b0;
        foreach (bq[i]) begin
            send_byte(bq[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, ok_b,
                      done_before);
            if (!ok_b) begin
                ok = 1'b0;
                break;
            end
        end
        // Words are written during the data phase whatever the trailer says.
        if (n >= 1 && n <= DEPTH)
            for (int i = 0; i < int'(n); i++) ref_mem[i] = img[i];
    endtask

    task automatic apply_reset();
        @(negedge clk1);
        reset = 1'b0;
        @(negedge clk1);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready got %b want 0", rx_ready); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got %b want 1", core_reset); end
        checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b want 00", load_done, load_error); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL rst_instr got %h want %h", instr, NOP); end
        @(negedge clk1);
        reset = 1'b1;
        #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rel_rx_ready_early got %b want 0", rx_ready); end
        @(negedge clk1);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rel_rx_ready got %b want 1", rx_ready); end
    endtask

    task automatic test_basic();
        bit ok; logic db;
        img = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        chk_delta = 0;
        load_image(32'd3, 0, ok, db);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_handshake got timeout want accept"); end
        checks++; if (db !== 1'b0) begin errors++; $display("FAIL basic_done_early got %b want 0", db); end
        checks++; if (load_done !== 1'b1 || core_reset !== 1'b0) begin errors++; $display("FAIL basic_done got done=%b core_reset=%b want 1/0", load_done, core_reset); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL basic_rx_ready got %b want 0", rx_ready); end
        pc = 32'h8; #1;
        checks++; if (instr !== 32'h0020_81B3) begin errors++; $display("FAIL basic_pc8 got %h want 002081b3", instr); end
        for (int i = 0; i < 3; i++) begin
            pc = {20'h0, 10'(i), 2'(i)}; #1;
            checks++; if (instr !== ref_mem[i]) begin errors++; $display("FAIL basic_fetch%0d got %h want %h", i, instr, ref_mem[i]); end
        end
        rx_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk1);
            checks++; if (rx_ready !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL basic_terminal got ready=%b done=%b want 0/1", rx_ready, load_done); end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_zero();
        bit ok; logic db;
        apply_reset();
        img = {};
        chk_delta = 0;
        load_image(32'd0, 0, ok, db);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL zero_handshake got timeout want accept"); end
        checks++; if (db !== 1'b0 || load_done !== 1'b1 || core_reset !== 1'b0) begin errors++; $display("FAIL zero_done got before=%b done=%b core_reset=%b want 0/1/0", db, load_done, core_reset); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL zero_rx_ready got %b want 0", rx_ready); end
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i * 4); #1;
            checks++; if (instr !== ref_mem[i]) begin errors++; $display("FAIL zero_stale%0d got %h want %h", i, instr, ref_mem[i]); end
        end
    endtask

    task automatic test_overflow();
        bit ok; logic db;
        logic [31:0] bad [2];
        bad[0] = DEPTH + 1;
        bad[1] = 32'h8000_0000 | DEPTH;
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            load_image(bad[k], 0, ok, db);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf%0d_handshake got timeout want accept", k); end
            checks++; if (load_error !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL ovf%0d_flags got err=%b core_reset=%b done=%b want 1/1/0", k, load_error, core_reset, load_done); end
            rx_valid = 1'b1;
            repeat (3) @(negedge clk1);
            checks++; if (rx_ready !== 1'b0 || load_error !== 1'b1) begin errors++; $display("FAIL ovf%0d_terminal got ready=%b err=%b want 0/1", k, rx_ready, load_error); end
            rx_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                pc = $urandom; #1;
                checks++; if (instr !== NOP) begin errors++; $display("FAIL ovf%0d_instr pc=%h got %h want %h", k, pc, instr, NOP); end
            end
        end
    endtask

    task automatic test_gaps();
        bit ok; logic db;
        apply_reset();
        img = '{$urandom, $urandom};
        chk_delta = 0;
        load_image(32'd2, 20, ok, db);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gaps_handshake got timeout want accept"); end
        checks++; if (db !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL gaps_done got before=%b after=%b want 0/1", db, load_done); end
        for (int i = 0; i < 2; i++) begin
            pc = 32'(i * 4); #1;
            checks++; if (instr !== ref_mem[i]) begin errors++; $display("FAIL gaps_fetch%0d got %h want %h", i, instr, ref_mem[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; logic db;
        logic [7:0] part [6];
        part = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        @(negedge clk1);
        #2 reset = 1'b0;
        #1;
        checks++; if (core_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL mid_run_reset got core_reset=%b done=%b want 1/0", core_reset, load_done); end
        @(negedge clk1);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(part[i], 0, ok, db);
        #2 reset = 1'b0;
        #1;
        checks++; if (core_reset !== 1'b1 || rx_ready !== 1'b0) begin errors++; $display("FAIL mid_load_reset got core_reset=%b ready=%b want 1/0", core_reset, rx_ready); end
        @(negedge clk1);
        reset = 1'b1;
        img = '{$urandom, $urandom};
        chk_delta = 0;
        load_image(32'd2, 2, ok, db);
        checks++; if (ok !== 1'b1 || load_done !== 1'b1) begin errors++; $display("FAIL mid_reload got ok=%b done=%b want 1/1", ok, load_done); end
        for (int i = 0; i < 2; i++) begin
            pc = 32'(i * 4); #1;
            checks++; if (instr !== img[i]) begin errors++; $display("FAIL mid_fetch%0d got %h want %h", i, instr, img[i]); end
        end
        pc = 32'h1000; #1;
        checks++; if (instr !== img[0]) begin errors++; $display("FAIL mid_alias got %h want %h", instr, img[0]); end
    endtask

    task automatic test_random();
        bit ok; logic db;
        int unsigned n;
        int unsigned idx;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            n = $urandom_range(1, 16);
            img = {};
            for (int i = 0; i < int'(n); i++) img.push_back($urandom);
            chk_delta = 0;
            load_image(n, 3, ok, db);
            checks++; if (ok !== 1'b1 || db !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL rand%0d_done got ok=%b before=%b after=%b want 1/0/1", it, ok, db, load_done); end
            for (int j = 0; j < 8; j++) begin
                idx = $urandom_range(0, 31);
                pc = {$urandom_range(0, 32'hFFFFF), 10'(idx), 2'($urandom)}; #1;
                checks++; if (instr !== ref_mem[idx]) begin errors++; $display("FAIL rand%0d_fetch pc=%h got %h want %h", it, pc, instr, ref_mem[idx]); end
            end
        end
    endtask

    task automatic test_full_depth();
        bit ok; logic db;
        int bad;
        apply_reset();
        img = {};
        for (int i = 0; i < int'(DEPTH); i++) img.push_back($urandom);
        chk_delta = 0;
        load_image(DEPTH, 0, ok, db);
        checks++; if (ok !== 1'b1 || load_done !== 1'b1 || load_error !== 1'b0) begin errors++; $display("FAIL full_done got ok=%b done=%b err=%b want 1/1/0", ok, load_done, load_error); end
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            pc = 32'(i * 4); #1;
            if (instr !== ref_mem[i]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_fetch got %0d wrong words want 0", bad); end
    endtask

`ifdef IMEM_CHECKSUM_EN
    task automatic test_checksum();
        bit ok; logic db;
        apply_reset();
        img = '{32'h1, 32'h2};
        chk_delta = 0;
        load_image(32'd2, 0, ok, db);
        checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin errors++; $display("FAIL chk_good got done=%b err=%b want 1/0", load_done, load_error); end
        apply_reset();
        chk_delta = 1;
        load_image(32'd2, 0, ok, db);
        checks++; if (load_error !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL chk_bad got err=%b core_reset=%b done=%b want 1/1/0", load_error, core_reset, load_done); end
        chk_delta = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_random();
        test_full_depth();
`ifdef IMEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
